// File: rtl/kws_decision_filter.sv
// kws_decision_filter
// Smooths the per-inference winner of the keyword-spotting accelerator with a
// sliding-window majority vote before it reaches the Result/Inf_Done pins.
// Weak winners (score below threshold) and out-of-range classes are recorded
// as the silence class; a detection starts a hold-off of accepted inferences.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_en              filter enable (0 keeps the filter flushed)
//   flush               one-cycle clear of history, counters, fill, hold-off
//   cfg_win_len         vote window length W (0 -> 1, > HIST_DEPTH -> HIST_DEPTH)
//   cfg_min_votes       votes needed for a detection
//   cfg_score_th        signed score threshold
//   cfg_silence_class   class index that never counts as a detection
//   cfg_holdoff         accepted inferences suppressed after a detection
//   inf_valid/inf_ready input handshake; inf_class/inf_score winner data
//   Inf_Done            one-cycle pulse per processed inference
//   Result              last detected class (held)
//   det_valid           one-cycle detection pulse, concurrent with Inf_Done
//   det_votes           vote count of the window winner
module kws_decision_filter #(
    parameter int N_CLASS    = 12,
    parameter int HIST_DEPTH = 8,
    parameter int SCORE_W    = 16,
    localparam int CLASS_W   = $clog2(N_CLASS),
    localparam int VOTE_W    = $clog2(HIST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_en,
    input  logic               flush,
    input  logic [VOTE_W-1:0]  cfg_win_len,
    input  logic [VOTE_W-1:0]  cfg_min_votes,
    input  logic [SCORE_W-1:0] cfg_score_th,
    input  logic [CLASS_W-1:0] cfg_silence_class,
    input  logic [7:0]         cfg_holdoff,
    input  logic               inf_valid,
    output logic               inf_ready,
    input  logic [CLASS_W-1:0] inf_class,
    input  logic [SCORE_W-1:0] inf_score,
    output logic               Inf_Done,
    output logic [CLASS_W-1:0] Result,
    output logic               det_valid,
    output logic [VOTE_W-1:0]  det_votes
);

    localparam int PTR_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    // One counter per encodable class index so that a silence class outside
    // 0..N_CLASS-1 still has a slot; only 0..N_CLASS-1 take part in the scan.
    localparam int N_SLOT = 2 ** CLASS_W;

    typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DECIDE} state_t;

    state_t             state_reg;
    logic [CLASS_W-1:0] hist_reg [HIST_DEPTH];
    logic [VOTE_W-1:0]  cnt_reg  [N_SLOT];
    logic [VOTE_W-1:0]  fill_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [7:0]         holdoff_cnt_reg;

    // Inference and configuration captured at acceptance.
    logic [CLASS_W-1:0] label_reg;
    logic [VOTE_W-1:0]  win_reg;
    logic [VOTE_W-1:0]  min_votes_reg;
    logic [CLASS_W-1:0] silence_reg;
    logic [7:0]         holdoff_cfg_reg;

    logic [CLASS_W-1:0] scan_idx_reg;
    logic [CLASS_W-1:0] best_class_reg;
    logic [VOTE_W-1:0]  best_votes_reg;

    logic [VOTE_W-1:0]  win_eff;
    logic [CLASS_W-1:0] label_in;
    logic [PTR_W:0]     ev_sum;
    logic [PTR_W-1:0]   ev_ptr;
    logic [CLASS_W-1:0] ev_class;
    logic               accept;

    // Ready is masked by rst so every output reads 0 while reset is applied.
    assign inf_ready = (state_reg == IDLE) && cfg_en && !flush && !rst;
    assign accept    = inf_valid && inf_ready;

    always_comb begin
        win_eff = cfg_win_len;
        if (cfg_win_len == '0)
            win_eff = VOTE_W'(1);
        else if (cfg_win_len > VOTE_W'(HIST_DEPTH))
            win_eff = VOTE_W'(HIST_DEPTH);
    end

    always_comb begin
        label_in = inf_class;
        if (($signed(inf_score) < $signed(cfg_score_th)) || (int'(inf_class) >= N_CLASS))
            label_in = cfg_silence_class;
    end

    // Oldest entry of the window: (wr_ptr - W) mod HIST_DEPTH, computed
    // without going negative.
    always_comb begin
        ev_sum = {1'b0, wr_ptr_reg} + (PTR_W+1)'(HIST_DEPTH) - (PTR_W+1)'(win_reg);
        if (ev_sum >= (PTR_W+1)'(HIST_DEPTH))
            ev_sum = ev_sum - (PTR_W+1)'(HIST_DEPTH);
        ev_ptr   = ev_sum[PTR_W-1:0];
        ev_class = hist_reg[ev_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            for (int i = 0; i < HIST_DEPTH; i++) hist_reg[i] <= '0;
            for (int i = 0; i < N_SLOT; i++)     cnt_reg[i]  <= '0;
            fill_reg        <= '0;
            wr_ptr_reg      <= '0;
            holdoff_cnt_reg <= '0;
            label_reg       <= '0;
            win_reg         <= '0;
            min_votes_reg   <= '0;
            silence_reg     <= '0;
            holdoff_cfg_reg <= '0;
            scan_idx_reg    <= '0;
            best_class_reg  <= '0;
            best_votes_reg  <= '0;
            Inf_Done        <= 1'b0;
            det_valid       <= 1'b0;
            Result          <= '0;
            det_votes       <= '0;
        end else begin
            Inf_Done  <= 1'b0;
            det_valid <= 1'b0;
            if (flush || !cfg_en) begin
                // Abort anything in flight; Result and det_votes are held.
                state_reg       <= IDLE;
                for (int i = 0; i < HIST_DEPTH; i++) hist_reg[i] <= '0;
                for (int i = 0; i < N_SLOT; i++)     cnt_reg[i]  <= '0;
                fill_reg        <= '0;
                wr_ptr_reg      <= '0;
                holdoff_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            label_reg       <= label_in;
                            win_reg         <= win_eff;
                            min_votes_reg   <= cfg_min_votes;
                            silence_reg     <= cfg_silence_class;
                            holdoff_cfg_reg <= cfg_holdoff;
                            state_reg       <= UPDATE;
                        end
                    end
                    UPDATE: begin
                        hist_reg[wr_ptr_reg] <= label_reg;
                        if (wr_ptr_reg == PTR_W'(HIST_DEPTH - 1))
                            wr_ptr_reg <= '0;
                        else
                            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                        if (fill_reg == win_reg) begin
                            // Full window: evict the oldest label; a matching
                            // eviction leaves all counters unchanged.
                            if (ev_class != label_reg) begin
                                cnt_reg[ev_class]  <= cnt_reg[ev_class] - VOTE_W'(1);
                                cnt_reg[label_reg] <= cnt_reg[label_reg] + VOTE_W'(1);
                            end
                        end else begin
                            cnt_reg[label_reg] <= cnt_reg[label_reg] + VOTE_W'(1);
                            fill_reg           <= fill_reg + VOTE_W'(1);
                        end
                        scan_idx_reg   <= '0;
                        best_class_reg <= '0;
                        best_votes_reg <= '0;
                        state_reg      <= SCAN;
                    end
                    SCAN: begin
                        // Strict compare keeps the lowest index on ties.
                        if (cnt_reg[scan_idx_reg] > best_votes_reg) begin
                            best_votes_reg <= cnt_reg[scan_idx_reg];
                            best_class_reg <= scan_idx_reg;
                        end
                        if (scan_idx_reg == CLASS_W'(N_CLASS - 1))
                            state_reg <= DECIDE;
                        else
                            scan_idx_reg <= scan_idx_reg + CLASS_W'(1);
                    end
                    DECIDE: begin
                        Inf_Done  <= 1'b1;
                        det_votes <= best_votes_reg;
                        if ((fill_reg == win_reg) && (best_class_reg != silence_reg) &&
                            (best_votes_reg >= min_votes_reg) && (holdoff_cnt_reg == 8'd0)) begin
                            Result          <= best_class_reg;
                            det_valid       <= 1'b1;
                            holdoff_cnt_reg <= holdoff_cfg_reg;
                        end else if (holdoff_cnt_reg != 8'd0) begin
                            holdoff_cnt_reg <= holdoff_cnt_reg - 8'd1;
                        end
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kws_decision_filter.sv
// Self-checking bench for kws_decision_filter (N_CLASS=12, HIST_DEPTH=8).
// A behavioural model recomputes the window vote from a label queue and
// pushes the expected outcome of each inference onto a scoreboard; the entry
// is popped and compared when Inf_Done fires.
module tb_kws_decision_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic        flush;
    logic [3:0]  cfg_win_len;
    logic [3:0]  cfg_min_votes;
    logic [15:0] cfg_score_th;
    logic [3:0]  cfg_silence_class;
    logic [7:0]  cfg_holdoff;
    logic        inf_valid;
    logic        inf_ready;
    logic [3:0]  inf_class;
    logic [15:0] inf_score;
    logic        inf_done;
    logic [3:0]  result;
    logic        det_valid;
    logic [3:0]  det_votes;

    kws_decision_filter dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_en            (cfg_en),
        .flush             (flush),
        .cfg_win_len       (cfg_win_len),
        .cfg_min_votes     (cfg_min_votes),
        .cfg_score_th      (cfg_score_th),
        .cfg_silence_class (cfg_silence_class),
        .cfg_holdoff       (cfg_holdoff),
        .inf_valid         (inf_valid),
        .inf_ready         (inf_ready),
        .inf_class         (inf_class),
        .inf_score         (inf_score),
        .Inf_Done          (inf_done),
        .Result            (result),
        .det_valid         (det_valid),
        .det_votes         (det_votes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       det;
        logic [3:0] res;
        logic [3:0] votes;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_win[$];
    int         m_w, m_minv, m_th, m_sil, m_hold_cfg, m_hold;
    logic [3:0] m_res;
    int         checks   = 0;
    int         failures = 0;
    int         txn      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: recount the whole window each time.
    task automatic model_push(input logic [3:0] c, input logic signed [15:0] s);
        logic [3:0] lab;
        int         v[16];
        int         bv, bc;
        exp_t       e;
        lab = ((int'(s) < m_th) || (c >= 4'd12)) ? 4'(m_sil) : c;
        m_win.push_back(lab);
        if (m_win.size() > m_w) void'(m_win.pop_front());
        for (int i = 0; i < 16; i++) v[i] = 0;
        foreach (m_win[j]) v[m_win[j]]++;
        bv = 0;
        bc = 0;
        for (int i = 0; i < 12; i++) if (v[i] > bv) begin bv = v[i]; bc = i; end
        e.det = (m_win.size() == m_w) && (bc != m_sil) && (bv >= m_minv) && (m_hold == 0);
        if (e.det) begin
            m_res  = 4'(bc);
            m_hold = m_hold_cfg;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        e.res   = m_res;
        e.votes = 4'(bv);
        sb.push_back(e);
    endtask

    task automatic set_cfg(input int w, input int minv, input int th, input int sil, input int hold);
        @(negedge clk);
        cfg_en            = 1'b0;
        cfg_win_len       = 4'(w);
        cfg_min_votes     = 4'(minv);
        cfg_score_th      = 16'(th);
        cfg_silence_class = 4'(sil);
        cfg_holdoff       = 8'(hold);
        m_w        = (w == 0) ? 1 : ((w > 8) ? 8 : w);
        m_minv     = minv;
        m_th       = th;
        m_sil      = sil;
        m_hold_cfg = hold;
        m_hold     = 0;
        m_win.delete();
        @(negedge clk);
        cfg_en = 1'b1;
    endtask

    task automatic accept_only(input logic [3:0] c, input int s);
        int n;
        @(negedge clk);
        inf_valid = 1'b1;
        inf_class = c;
        inf_score = 16'(s);
        n = 0;
        while (!inf_ready && n < 40) begin @(negedge clk); n++; end
        check("ready", inf_ready, 1);
        @(posedge clk);
        #1 inf_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input int s);
        int   n;
        exp_t e;
        model_push(c, 16'(s));
        accept_only(c, s);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!inf_done && n < 40);
        txn++;
        check("latency", n, 14);
        e = sb.pop_front();
        check("det_valid", det_valid, e.det);
        check("result", result, e.res);
        check("det_votes", det_votes, e.votes);
        $display("txn %0d class=%0d score=%0d det_valid=%0b result=%0d det_votes=%0d",
                 txn, c, s, det_valid, result, det_votes);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (inf_done) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; cfg_en = 1'b0; flush = 1'b0; inf_valid = 1'b0;
        inf_class = '0; inf_score = '0;
        cfg_win_len = 4'd4; cfg_min_votes = 4'd3; cfg_score_th = 16'd10;
        cfg_silence_class = '0; cfg_holdoff = '0;
        m_res = '0; m_hold = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", inf_done, 0);
        check("rst_det_valid", det_valid, 0);
        check("rst_result", result, 0);
        check("rst_det_votes", det_votes, 0);
        check("rst_ready", inf_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_cfg_off", inf_ready, 0);

        // Fill: detection only once the window is full.
        set_cfg(4, 3, 10, 0, 0);
        #1 check("ready_idle", inf_ready, 1);
        repeat (4) send(4'd5, 100);

        // Tie between 2 and 7: lowest index wins.
        set_cfg(4, 2, 10, 0, 0);
        send(4'd2, 50); send(4'd7, 50); send(4'd2, 50); send(4'd7, 50);

        // Threshold: weak scores become silence; score == threshold is kept.
        set_cfg(4, 3, 10, 0, 0);
        repeat (4) send(4'd3, 5);
        send(4'd3, 10);
        send(4'd3, -200);

        // Eviction and window sliding.
        set_cfg(4, 3, 10, 0, 0);
        send(4'd1, 100); send(4'd1, 100); send(4'd1, 100); send(4'd1, 100);
        send(4'd4, 100); send(4'd4, 100); send(4'd4, 100);

        // Wrap across HIST_DEPTH with W=5, negative threshold, invalid classes.
        set_cfg(5, 2, -50, 0, 0);
        for (int i = 0; i < 20; i++)
            send(4'($urandom_range(0, 13)), int'($urandom_range(0, 200)) - 100);
        // W above HIST_DEPTH clamps to 8; silence class 11.
        set_cfg(12, 5, 0, 11, 0);
        for (int i = 0; i < 12; i++)
            send(4'($urandom_range(0, 3)), int'($urandom_range(0, 100)) - 10);
        // W=0 behaves as W=1.
        set_cfg(0, 1, 0, 0, 0);
        send(4'd8, 20); send(4'd0, 20); send(4'd9, 20);

        // Hold-off of two accepted inferences.
        set_cfg(4, 3, 10, 0, 2);
        repeat (7) send(4'd5, 100);

        // Flush during SCAN aborts the inference.
        set_cfg(4, 3, 10, 0, 0);
        repeat (4) send(4'd6, 100);
        accept_only(4'd6, 100);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_win.delete();
        m_hold = 0;
        count_done(25, cnt);
        check("flush_no_done", cnt, 0);
        // Flush and valid together: flush wins.
        @(negedge clk);
        flush = 1'b1; inf_valid = 1'b1; inf_class = 4'd6; inf_score = 16'd100;
        #1 check("ready_during_flush", inf_ready, 0);
        @(negedge clk);
        flush = 1'b0; inf_valid = 1'b0;
        count_done(20, cnt);
        check("flush_valid_no_done", cnt, 0);
        repeat (4) send(4'd6, 100);

        // Asynchronous reset in the middle of UPDATE.
        accept_only(4'd9, 100);
        rst = 1'b1;
        #1;
        check("arst_done", inf_done, 0);
        check("arst_det_valid", det_valid, 0);
        check("arst_result", result, 0);
        check("arst_det_votes", det_votes, 0);
        check("arst_ready", inf_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        m_res = '0;
        set_cfg(1, 1, 10, 0, 0);
        send(4'd9, 100);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kws_decision_filter.md
Name: kws_decision_filter

Overview:
- Post-processing stage between the Tsetlin machine accelerator's per-inference winner and the chip-level Result/Inf_Done pins.
- Replaces the single-shot result with a parametrised sliding-window majority vote over the last W inferences.
- Adds a score threshold that maps weak winners to a silence class, plus a detection hold-off.
- Generalises class count and history depth; adds flush and a ready/valid input handshake.

Parameters:
- N_CLASS, 12, number of keyword classes including silence.
- HIST_DEPTH, 8, maximum vote window length (history buffer entries).
- SCORE_W, 16, width of the signed winning-class sum.
- CLASS_W, $clog2(N_CLASS), localparam, class index width.
- VOTE_W, $clog2(HIST_DEPTH+1), localparam, vote counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cfg_en  in  1  filter enable; 0 forces flush state
- flush  in  1  one-cycle clear of history, vote counters and fill count
- cfg_win_len  in  VOTE_W  window length W
- cfg_min_votes  in  VOTE_W  votes needed for a detection
- cfg_score_th  in  SCORE_W  signed score threshold
- cfg_silence_class  in  CLASS_W  class index treated as non-detection
- cfg_holdoff  in  8  accepted inferences suppressed after a detection
- inf_valid  in  1  winner available
- inf_ready  out  1  filter can accept
- inf_class  in  CLASS_W  winning class
- inf_score  in  SCORE_W  signed winning sum
- Inf_Done  out  1  one-cycle pulse per processed inference
- Result  out  CLASS_W  last detected class (held)
- det_valid  out  1  one-cycle pulse, concurrent with Inf_Done, when a detection occurs
- det_votes  out  VOTE_W  vote count of the window winner, updated with every Inf_Done

Behaviour:
- Reset (async, rst=1): all outputs are 0, state is IDLE, and history, counters, fill and holdoff count are all 0.
- Effective W: cfg_win_len clamped. 0 is treated as 1; values above HIST_DEPTH are treated as HIST_DEPTH. Config is sampled only in IDLE and must not change while cfg_en=1.
- Handshake:
  - inf_ready=1 only in IDLE with cfg_en=1 and flush=0.
  - Transfer occurs on the edge where inf_valid & inf_ready.
  - Upstream holds its data until transferred.
- Label rule: if inf_score < cfg_score_th (signed compare), the recorded label is cfg_silence_class; otherwise it is inf_class. inf_class >= N_CLASS is recorded as silence.
- FSM: IDLE -> UPDATE -> SCAN -> DECIDE -> IDLE.
  - UPDATE (1 cycle):
    - Write the label into the circular buffer at wr_ptr and increment its counter.
    - If fill == W, first decrement the counter of the evicted entry at position (wr_ptr - W) mod HIST_DEPTH. If evicted equals new, the counter is unchanged.
    - wr_ptr wraps at HIST_DEPTH. fill saturates at W.
  - SCAN (N_CLASS cycles): sequential argmax over the counters. Strict greater-than, so the lowest index wins ties.
  - DECIDE (1 cycle): register outputs.
- Latency: accept on edge k; Inf_Done, det_valid, Result and det_votes are registered on edge k+N_CLASS+2. Throughput is one inference per N_CLASS+3 cycles.
- Detection condition: fill == W, winner != cfg_silence_class, votes >= cfg_min_votes, and holdoff count == 0.
  - On detection: Result <= winner, det_valid pulses, holdoff count <= cfg_holdoff.
  - Otherwise: Result is held, and the holdoff count decrements if non-zero (once per accepted inference).
- flush or cfg_en=0:
  - Has priority in every state. Next edge clears buffer, counters, fill, wr_ptr and holdoff count, and returns to IDLE.
  - Aborts any in-flight inference with no Inf_Done pulse.
  - Result is held.
- Simultaneous flush and inf_valid: flush wins; the inference is not accepted (inf_ready=0).

Test Plan:
- Fill (N_CLASS=12, W=4, min_votes=3, th=10, silence=0, holdoff=0): four inferences of class 5 with score 100 -> Inf_Done x4 and det_valid=0 on the first three; on the 4th, det_valid=1, Result=5, det_votes=4, exactly 14 cycles after accept.
- Tie: window {2,7,2,7} with min_votes=2 -> Result=2, det_votes=2.
- Threshold: four inferences of class 3 with score 5 -> labels are silence; det_valid=0, Result unchanged (0), det_votes=4.
- Eviction/wrap: sequence 1,1,1,1,4,4,4 with W=4 -> after the 7th, counts are {1:1, 4:3}, Result=4, det_votes=3. Run 20 inferences across the HIST_DEPTH wrap and check that counters always sum to W.
- Holdoff=2: after a detection of class 5, the next two class-5 inferences give det_valid=0; the third gives det_valid=1.
- Flush asserted during SCAN -> no Inf_Done, fill=0, and the next 3 inferences give det_valid=0. rst asserted mid-UPDATE -> all outputs 0 combinationally-asynchronously, without waiting for a clk edge.
